// File: rtl/symm_scale_sub_if.sv
// Streaming bus for the symmetric-decorrelation scaler: W/M input beats in, scaled beats out.
interface symm_scale_sub_if #(
   parameter int unsigned W     = 26,
   parameter int unsigned LANES = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [LANES*W-1:0]   in_w;
   logic [LANES*W-1:0]   in_m;
   logic                 out_valid;
   logic                 out_ready;
   logic [LANES*W-1:0]   out_w;
   logic                 out_last;
   logic [LANES-1:0]     out_lane_sat;
   logic                 out_sat;

   modport master (
      output in_valid, in_w, in_m, out_ready,
      input  in_ready, out_valid, out_w, out_last, out_lane_sat, out_sat
   );

   modport slave (
      input  in_valid, in_w, in_m, out_ready,
      output in_ready, out_valid, out_w, out_last, out_lane_sat, out_sat
   );
endinterface

// File: rtl/symm_scale_sub.sv
// FastICA symmetric-decorrelation scaler: out = 1.5*w (mode 0) or 1.5*w - 0.5*m (mode 1),
// two-stage pipeline with matrix framing, floor/round-half-up and saturation.
module symm_scale_sub #(
   parameter int unsigned W     = 26,
   parameter int unsigned N     = 4,
   parameter int unsigned LANES = 4
) (
   input logic              clk_symm,
   input logic              rst_symm,
   input logic              mode_symm,
   input logic              rnd_symm,
   symm_scale_sub_if.slave  bus
);
   localparam int unsigned LW    = LANES * W;
   localparam int unsigned BEATS = (N * N) / LANES;
   localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned SW    = W + 3;
   localparam int unsigned RW    = W + 2;
   localparam logic [CW-1:0]        LAST_BEAT = CW'(BEATS - 1);
   localparam logic signed [RW-1:0] MAXV      = {3'b000, {(W-1){1'b1}}};
   localparam logic signed [RW-1:0] MINV      = {3'b111, {(W-1){1'b0}}};

   generate
      if (((N * N) % LANES) != 0 || W < 4) begin : g_bad_cfg
         $error("symm_scale_sub: N*N must be a multiple of LANES and W >= 4");
      end
   endgenerate

   logic                 adv;
   logic                 accept;
   logic                 beat0;
   logic [CW-1:0]        beat_cnt;
   logic                 mode_q;
   logic                 rnd_q;
   logic                 eff_mode;
   logic                 eff_rnd;

   logic                 s1_valid;
   logic                 s1_last;
   logic                 s1_rnd;
   logic signed [SW-1:0] s1_diff [LANES];
   logic signed [SW-1:0] diff_c  [LANES];

   logic [LW-1:0]        res_c;
   logic [LANES-1:0]     lsat_c;

   logic                 out_valid_q;
   logic [LW-1:0]        out_w_q;
   logic                 out_last_q;
   logic [LANES-1:0]     out_lane_sat_q;
   logic                 out_sat_q;
   logic                 sticky_q;

   // Whole pipeline advances together; in_ready is deliberately combinational from out_ready.
   assign adv      = !out_valid_q || bus.out_ready;
   assign accept   = bus.in_valid && adv;
   assign beat0    = (beat_cnt == '0);
   // Beat 0 uses the live mode/rnd; later beats use the values latched on beat 0.
   assign eff_mode = beat0 ? mode_symm : mode_q;
   assign eff_rnd  = beat0 ? rnd_symm  : rnd_q;

   assign bus.in_ready     = adv;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_w        = out_w_q;
   assign bus.out_last     = out_last_q;
   assign bus.out_lane_sat = out_lane_sat_q;
   assign bus.out_sat      = out_sat_q;

   // Stage 1: s = 3*w - (mode ? m : 0), wide enough that it cannot overflow.
   always_comb begin : p_stage1
      logic signed [SW-1:0] w_ext;
      logic signed [SW-1:0] m_ext;
      w_ext = '0;
      m_ext = '0;
      for (int k = 0; k < LANES; k++) begin
         w_ext     = SW'($signed(bus.in_w[k*W +: W]));
         m_ext     = SW'($signed(bus.in_m[k*W +: W]));
         diff_c[k] = (w_ext <<< 1) + w_ext - (eff_mode ? m_ext : SW'(0));
      end
   end

   // Stage 2: optional half-up bias, arithmetic halve, clip to the W-bit range.
   always_comb begin : p_stage2
      logic signed [SW-1:0] t;
      logic signed [RW-1:0] r;
      t      = '0;
      r      = '0;
      res_c  = '0;
      lsat_c = '0;
      for (int k = 0; k < LANES; k++) begin
         t = s1_diff[k] + $signed({{(SW-1){1'b0}}, s1_rnd});
         r = RW'(t >>> 1);
         if (r > MAXV) begin
            res_c[k*W +: W] = MAXV[W-1:0];
            lsat_c[k]       = 1'b1;
         end else if (r < MINV) begin
            res_c[k*W +: W] = MINV[W-1:0];
            lsat_c[k]       = 1'b1;
         end else begin
            res_c[k*W +: W] = r[W-1:0];
         end
      end
   end

   always_ff @(posedge clk_symm) begin
      if (rst_symm) begin
         beat_cnt       <= '0;
         mode_q         <= 1'b0;
         rnd_q          <= 1'b0;
         s1_valid       <= 1'b0;
         s1_last        <= 1'b0;
         s1_rnd         <= 1'b0;
         s1_diff        <= '{default: '0};
         out_valid_q    <= 1'b0;
         out_w_q        <= '0;
         out_last_q     <= 1'b0;
         out_lane_sat_q <= '0;
         out_sat_q      <= 1'b0;
         sticky_q       <= 1'b0;
      end else begin
         if (accept) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            if (beat0) begin
               mode_q <= mode_symm;
               rnd_q  <= rnd_symm;
            end
         end
         if (adv) begin
            s1_valid       <= accept;
            s1_last        <= accept && (beat_cnt == LAST_BEAT);
            s1_rnd         <= eff_rnd;
            s1_diff        <= diff_c;
            out_valid_q    <= s1_valid;
            out_w_q        <= res_c;
            out_last_q     <= s1_valid && s1_last;
            out_lane_sat_q <= s1_valid ? lsat_c : '0;
            out_sat_q      <= s1_valid && s1_last && (sticky_q || (|lsat_c));
            // Sticky collects the matrix's saturations and restarts after its last beat.
            if (s1_valid) begin
               sticky_q <= s1_last ? 1'b0 : (sticky_q || (|lsat_c));
            end
         end
      end
   end
endmodule

// File: tb/tb_symm_scale_sub.sv
// Self-checking bench for symm_scale_sub: arithmetic model plus directed literal checks.
module tb_symm_scale_sub;
   localparam int unsigned W     = 26;
   localparam int unsigned N     = 4;
   localparam int unsigned LANES = 4;
   localparam int unsigned BEATS = (N * N) / LANES;
   localparam int unsigned LW    = LANES * W;
   localparam longint      VMAX  = (longint'(1) <<< (W - 1)) - 1;
   localparam longint      VMIN  = -(longint'(1) <<< (W - 1));
   localparam int          IMAX  = 33554431;
   localparam int          IMIN  = -33554432;

   typedef struct packed {
      logic [LW-1:0]    w;
      logic [LANES-1:0] ls;
      logic             last;
      logic             sat;
   } beat_t;

   logic clk_symm  = 1'b0;
   logic rst_symm  = 1'b1;
   logic mode_symm = 1'b0;
   logic rnd_symm  = 1'b0;

   symm_scale_sub_if #(.W(W), .LANES(LANES)) bus ();

   symm_scale_sub #(.W(W), .N(N), .LANES(LANES)) dut (
      .clk_symm  (clk_symm),
      .rst_symm  (rst_symm),
      .mode_symm (mode_symm),
      .rnd_symm  (rnd_symm),
      .bus       (bus)
   );

   always #5 clk_symm = ~clk_symm;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   beat_t            exp_q[$];
   logic [LW-1:0]    obs_w[$];
   logic [LANES-1:0] obs_ls[$];
   logic             obs_last[$];
   logic             obs_sat[$];
   int               obs_cyc[$];

   int    m_cnt  = 0;
   logic  m_mode = 1'b0;
   logic  m_rnd  = 1'b0;
   logic  m_acc  = 1'b0;
   logic  prev_stall = 1'b0;
   beat_t prev_out;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [LW-1:0] pk(input int a, input int b, input int c, input int d);
      return {W'(d), W'(c), W'(b), W'(a)};
   endfunction

   always @(posedge clk_symm) cyc++;

   // Model: expected result per accepted input beat, checked against each accepted output beat.
   always @(negedge clk_symm) begin : p_monitor
      beat_t  e;
      longint wv, mv, v;
      if (rst_symm) begin
         exp_q.delete();
         m_cnt      = 0;
         m_acc      = 1'b0;
         prev_stall = 1'b0;
      end else begin
         chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
         if (prev_stall) begin
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_w", bus.out_w, prev_out.w);
            chk("hold_last", bus.out_last, prev_out.last);
            chk("hold_ls", bus.out_lane_sat, prev_out.ls);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_out: got beat %0h expected none (cycle %0d)", bus.out_w, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("out_w", bus.out_w, e.w);
               chk("out_lane_sat", bus.out_lane_sat, e.ls);
               chk("out_last", bus.out_last, e.last);
               if (e.last) chk("out_sat", bus.out_sat, e.sat);
            end
            obs_w.push_back(bus.out_w);
            obs_ls.push_back(bus.out_lane_sat);
            obs_last.push_back(bus.out_last);
            obs_sat.push_back(bus.out_sat);
            obs_cyc.push_back(cyc);
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_out   = '{w: bus.out_w, ls: bus.out_lane_sat, last: bus.out_last, sat: bus.out_sat};
         if (bus.in_valid && bus.in_ready) begin
            e = '0;
            if (m_cnt == 0) begin
               m_mode = mode_symm;
               m_rnd  = rnd_symm;
            end
            for (int k = 0; k < LANES; k++) begin
               wv = $signed(bus.in_w[k*W +: W]);
               mv = $signed(bus.in_m[k*W +: W]);
               v  = 3 * wv - (m_mode ? mv : 64'sd0) + (m_rnd ? 64'sd1 : 64'sd0);
               v  = (v - (v & 64'sd1)) / 2;
               if (v > VMAX) begin
                  v = VMAX;
                  e.ls[k] = 1'b1;
               end else if (v < VMIN) begin
                  v = VMIN;
                  e.ls[k] = 1'b1;
               end
               e.w[k*W +: W] = W'(v);
            end
            m_acc  = m_acc | (|e.ls);
            e.last = (m_cnt == BEATS - 1);
            if (e.last) begin
               e.sat = m_acc;
               m_acc = 1'b0;
            end
            m_cnt = (m_cnt + 1) % BEATS;
            exp_q.push_back(e);
         end
      end
   end

   task automatic send(input logic [LW-1:0] w, input logic [LW-1:0] m, input logic md, input logic rd);
      bit ok;
      ok           = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_w     = w;
      bus.in_m     = m;
      mode_symm    = md;
      rnd_symm     = rd;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_symm);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
      end
      @(posedge clk_symm);
      #1;
   endtask

   // Interesting beat first, then three fillers driven with the opposite mode/rnd.
   task automatic send_mat(input logic [LW-1:0] w, input logic [LW-1:0] m, input logic md, input logic rd);
      send(w, m, md, rd);
      for (int i = 0; i < 3; i++) send(pk(1, -1, 3, -3), pk(1, 1, -1, -1), !md, !rd);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk_symm);
      #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, bus.out_valid, 1'b0);
      chk({tag, "_w"}, bus.out_w, '0);
      chk({tag, "_last"}, bus.out_last, 1'b0);
      chk({tag, "_ls"}, bus.out_lane_sat, '0);
      chk({tag, "_sat"}, bus.out_sat, 1'b0);
   endtask

   initial begin : p_main
      int base;
      bus.in_valid  = 1'b0;
      bus.in_w      = '0;
      bus.in_m      = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk_symm);
      #1;
      chk_reset_outputs("rst");
      rst_symm = 1'b0;

      // Mode 0 floor, with latency check on the first beat.
      send(pk(2, -3, 0, 1), '0, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      @(negedge clk_symm);
      chk("lat_cycle1", bus.out_valid, 1'b0);
      @(negedge clk_symm);
      chk("lat_cycle2", bus.out_valid, 1'b1);
      @(posedge clk_symm);
      #1;
      for (int i = 0; i < 3; i++) send(pk(1, -1, 3, -3), pk(1, 1, -1, -1), 1'b1, 1'b1);
      send_mat(pk(2, -3, 0, 1), '0, 1'b0, 1'b1);
      send_mat(pk(4, 1, -2, 0), pk(2, 0, 2, -1), 1'b1, 1'b0);
      send_mat(pk(4, 1, -2, 0), pk(2, 0, 2, -1), 1'b1, 1'b1);
      // Saturation on beat 1 only, then mode-1 saturation, then a clean matrix with a mid toggle.
      send('0, '0, 1'b0, 1'b0);
      send(pk(IMAX, IMIN, 0, 0), '0, 1'b0, 1'b0);
      send('0, '0, 1'b0, 1'b0);
      send('0, '0, 1'b0, 1'b0);
      send(pk(IMAX, 0, 0, 0), pk(IMIN, 0, 0, 0), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) send('0, '0, 1'b1, 1'b0);
      send('0, '0, 1'b0, 1'b0);
      send('0, '0, 1'b0, 1'b0);
      send(pk(2, 2, 2, 2), pk(2, 2, 2, 2), 1'b1, 1'b0);
      send(pk(2, 2, 2, 2), pk(2, 2, 2, 2), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) send(pk(2, 2, 2, 2), pk(2, 2, 2, 2), 1'b1, 1'b0);
      bus.in_valid = 1'b0;
      drain();

      if (obs_w.size() < 32) begin
         n_cmp++;
         n_err++;
         $display("FAIL obs_count: got %0d beats expected 32", obs_w.size());
      end else begin
         chk("m0_rnd0", obs_w[0], pk(3, -5, 0, 1));
         chk("m0_rnd1", obs_w[4], pk(3, -4, 0, 2));
         chk("m1_rnd0", obs_w[8], pk(5, 1, -4, 0));
         chk("m1_rnd1", obs_w[12], pk(5, 2, -4, 1));
         chk("sat0_w", obs_w[17], pk(IMAX, IMIN, 0, 0));
         chk("sat0_ls", obs_ls[17], 4'b0011);
         chk("sat0_matrix", obs_sat[19], 1'b1);
         chk("sat1_w", obs_w[20], pk(IMAX, 0, 0, 0));
         chk("sat1_ls", obs_ls[20], 4'b0001);
         chk("sat1_matrix", obs_sat[23], 1'b1);
         chk("clean_matrix", obs_sat[27], 1'b0);
         chk("toggle_ignored", obs_w[26], pk(3, 3, 3, 3));
         chk("toggle_applied", obs_w[28], pk(2, 2, 2, 2));
         chk("last_b2", obs_last[2], 1'b0);
         chk("last_b3", obs_last[3], 1'b1);
         chk("last_b7", obs_last[7], 1'b1);
         chk("last_b11", obs_last[11], 1'b1);
      end

      // Backpressure: 12 continuous beats with out_ready low for 3 cycles mid-stream.
      base = obs_w.size();
      fork
         begin
            for (int i = 0; i < 12; i++) send(pk(i, -i, 2 * i, 7 - i), pk(i, i, -i, 0), 1'(i % 2), 1'b0);
            bus.in_valid = 1'b0;
         end
         begin
            repeat (5) @(posedge clk_symm);
            #1;
            bus.out_ready = 1'b0;
            repeat (3) @(posedge clk_symm);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_count", 32'(obs_w.size() - base), 32'd12);
      if (obs_w.size() - base == 12)
         chk("bp_span", 32'(obs_cyc[base + 11] - obs_cyc[base]), 32'd14);

      // Reset mid-matrix discards in-flight beats and restarts framing.
      base = obs_w.size();
      send(pk(5, 5, 5, 5), '0, 1'b0, 1'b0);
      send(pk(5, 5, 5, 5), '0, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      rst_symm     = 1'b1;
      @(posedge clk_symm);
      #1;
      rst_symm = 1'b0;
      chk_reset_outputs("midrst");
      for (int i = 0; i < 4; i++) send(pk(1, 2, 3, 4), '0, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      drain();
      chk("rst_count", 32'(obs_w.size() - base), 32'd4);
      if (obs_w.size() - base == 4) begin
         chk("rst_first_w", obs_w[base], pk(1, 3, 4, 6));
         chk("rst_last_b2", obs_last[base + 2], 1'b0);
         chk("rst_last_b3", obs_last[base + 3], 1'b1);
      end
      chk("final_queue", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : p_watchdog
      #200000;
      n_err++;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end
endmodule
